// File: rtl/sha3_feeder_pkg.sv
// rtl/sha3_feeder_pkg.sv - shared types and constants for the SHA3 scan feeder
//
// Contents:
//   feeder_state_t       - LOAD, ARM, WAIT_DISP, RUN, REPORT
//   JOB_WORDS            - job length in 32-bit words (2 threshold + 24 header)
//   STATUS_*             - bit positions inside the status word of the result packet
//   pkt_words()          - result packet length for a given number of hash lanes

package sha3_feeder_pkg;

  typedef enum logic [2:0] {
    LOAD,
    ARM,
    WAIT_DISP,
    RUN,
    REPORT
  } feeder_state_t;

  localparam int JOB_WORDS          = 26;
  localparam int STATUS_FOUND_BIT   = 0;
  localparam int STATUS_TIMEOUT_BIT = 1;
  localparam int STATUS_JOB_ID_LSB  = 16;

  // status + nonce + two words per 64-bit lane
  function automatic int pkt_words(input int hash_lanes);
    return 2 + 2 * hash_lanes;
  endfunction

endpackage

// File: rtl/sha3_result_serializer.sv
// rtl/sha3_result_serializer.sv - captures a word vector and streams it out with valid/ready/last
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              capture load_words and start a new packet
//   load_words        packet contents, word 0 in bits [31:0]
//   out_data          current word (stable while out_valid & ~out_ready)
//   out_valid         a word is pending
//   out_last          pending word is the final one
//   out_ready         consumer accepts the pending word
//   done              final word handshakes this cycle

module sha3_result_serializer #(
  parameter int N_WORDS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [N_WORDS*32-1:0]  load_words,
  output logic [31:0]            out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   done
);

  localparam int CW = $clog2(N_WORDS + 1);

  logic [N_WORDS*32-1:0] buf_q;
  logic [CW-1:0]         left_q;

  // The word on out_data is always the low slice; each handshake shifts the
  // next word down, so output data comes straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      left_q <= '0;
    end else if (load) begin
      buf_q  <= load_words;
      left_q <= CW'(N_WORDS);
    end else if (out_valid && out_ready) begin
      buf_q  <= buf_q >> 32;
      left_q <= left_q - 1'b1;
    end
  end

  assign out_data  = buf_q[31:0];
  assign out_valid = (left_q != '0);
  assign out_last  = (left_q == CW'(1));
  assign done      = out_valid & out_ready & out_last;

endmodule

// File: rtl/sha3_scan_feeder.sv
// rtl/sha3_scan_feeder.sv - host-side job loader, scan tracker and result reporter for one SHA3 nonce scanner
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   in_data/in_valid/in_ready         job word stream (threshold lo, hi, then 24 header words)
//   out_data/out_valid/out_last/out_ready  result packet stream
//   scan_start                        level start request, held in ARM until scan_ready
//   scan_threshold, scan_blobby       job held steady towards the scanner
//   scan_dispatching, scan_found, scan_ready, scan_nonce, scan_hash  scanner status/results
//   busy                              high whenever not in LOAD

module sha3_scan_feeder #(
  parameter int HASH_LANES      = 4,
  parameter int WATCHDOG_CYCLES = 0,
  parameter int JOB_WORDS       = sha3_feeder_pkg::JOB_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [31:0]        out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               scan_start,
  output logic [63:0]        scan_threshold,
  output logic [23:0][31:0]  scan_blobby,
  input  logic               scan_dispatching,
  input  logic               scan_found,
  input  logic               scan_ready,
  input  logic [31:0]        scan_nonce,
  input  logic [24:0][63:0]  scan_hash,
  output logic               busy
);

  import sha3_feeder_pkg::*;

  localparam int PKT_WORDS = pkt_words(HASH_LANES);

  feeder_state_t             state;
  logic [4:0]                word_cnt;
  logic [15:0]               job_id;
  logic [31:0]               wd_cnt;

  logic                      run_done;
  logic                      wd_expire;
  logic                      ser_load;
  logic                      ser_done;
  logic                      res_found;
  logic [PKT_WORDS*32-1:0]   pkt;

  // Only lanes below HASH_LANES are reported; fold the whole bus so the
  // remaining lanes are visibly consumed.
  logic                      unused_hash;
  assign unused_hash = ^scan_hash;

  // The result packet is assembled from the scanner outputs in the cycle the
  // scan ends and captured straight into the serializer, which then serves as
  // the result register bank.
  always_comb begin
    run_done  = (state == RUN) && !scan_dispatching && scan_ready;
    // completion beats a watchdog expiry landing on the same cycle
    wd_expire = (WATCHDOG_CYCLES != 0)
              && ((state == WAIT_DISP) || (state == RUN))
              && (wd_cnt == 32'(WATCHDOG_CYCLES - 1))
              && !run_done;
    ser_load  = run_done || wd_expire;
    res_found = run_done && scan_found;

    pkt = '0;
    pkt[STATUS_FOUND_BIT]          = res_found;
    pkt[STATUS_TIMEOUT_BIT]        = wd_expire;
    pkt[STATUS_JOB_ID_LSB +: 16]   = job_id;
    if (res_found) begin
      pkt[63:32] = scan_nonce;
      for (int i = 0; i < HASH_LANES; i++) begin
        pkt[(2 + 2*i)*32 +: 32] = scan_hash[i][31:0];
        pkt[(3 + 2*i)*32 +: 32] = scan_hash[i][63:32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LOAD;
      word_cnt       <= '0;
      job_id         <= '0;
      wd_cnt         <= '0;
      in_ready       <= 1'b0;
      scan_start     <= 1'b0;
      scan_threshold <= '0;
      scan_blobby    <= '0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (word_cnt == 5'd0)
              scan_threshold[31:0] <= in_data;
            else if (word_cnt == 5'd1)
              scan_threshold[63:32] <= in_data;
            else
              scan_blobby[word_cnt - 5'd2] <= in_data;

            if (word_cnt == 5'(JOB_WORDS - 1)) begin
              word_cnt   <= '0;
              in_ready   <= 1'b0;
              scan_start <= 1'b1;
              state      <= ARM;
            end else begin
              word_cnt <= word_cnt + 5'd1;
            end
          end
        end

        ARM: begin
          wd_cnt <= '0;
          if (scan_ready) begin
            scan_start <= 1'b0;
            state      <= WAIT_DISP;
          end
        end

        // scan_ready is still high right after capture, so completion is
        // only recognised once dispatching has been seen.
        WAIT_DISP: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (ser_load)
            state <= REPORT;
          else if (scan_dispatching)
            state <= RUN;
        end

        RUN: begin
          wd_cnt <= wd_cnt + 32'd1;
          if (ser_load)
            state <= REPORT;
        end

        REPORT: begin
          if (ser_done) begin
            job_id   <= job_id + 16'd1;
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

  assign busy = (state != LOAD);

  sha3_result_serializer #(
    .N_WORDS (PKT_WORDS)
  ) u_serializer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ser_load),
    .load_words (pkt),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .done       (ser_done)
  );

endmodule
